// File: rtl/fp_conv_sched_if.sv
// Requester/readout bus of the shared floating-point converter scheduler.
// Carries out_ready only when FP_CONV_BACKPRESSURE_EN is defined.
interface fp_conv_sched_if #(
  parameter int NREQ = 4,
  parameter int TAGW = 2
);
  // Handshake: a requester holds req until its one-cycle ack; ack marks its sample
  // consumed and the out_* result valid. With backpressure a result transfers only
  // in a cycle where out_valid && out_ready.
  logic [NREQ-1:0]      req;
  logic [12*NREQ-1:0]   din;
  logic [NREQ-1:0]      ack;
  logic                 out_valid;
  logic [TAGW-1:0]      out_tag;
  logic                 out_s;
  logic [2:0]           out_e;
  logic [3:0]           out_f;
  logic                 busy;
  logic [1:0]           dbg_state;
`ifdef FP_CONV_BACKPRESSURE_EN
  logic                 out_ready;

  modport master (
    output req, din, out_ready,
    input  ack, out_valid, out_tag, out_s, out_e, out_f, busy, dbg_state
  );
  modport slave (
    input  req, din, out_ready,
    output ack, out_valid, out_tag, out_s, out_e, out_f, busy, dbg_state
  );
`else
  modport master (
    output req, din,
    input  ack, out_valid, out_tag, out_s, out_e, out_f, busy, dbg_state
  );
  modport slave (
    input  req, din,
    output ack, out_valid, out_tag, out_s, out_e, out_f, busy, dbg_state
  );
`endif
endinterface

// File: rtl/fp_conv_sched.sv
// Round-robin scheduler sharing one 12-bit -> S/E/F floating-point converter.
// Optional macro FP_CONV_BACKPRESSURE_EN adds out_ready and a WAIT state.
module fp_conv_sched #(
  parameter int NREQ = 4,
  parameter int TAGW = 2
) (
  input  logic           clk,
  input  logic           rst,
  fp_conv_sched_if.slave s_bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t          r_state, w_next;
  logic [TAGW-1:0] r_rr_ptr, r_tag_q, w_grant_idx, w_ptr_next;
  logic            w_grant_any;
  logic [11:0]     r_d_q, w_din_sel;
  logic            r_out_s;
  logic [2:0]      r_out_e;
  logic [3:0]      r_out_f;
  logic [TAGW-1:0] r_out_tag;
  logic            w_fire, w_valid;
  logic            w_cs;
  logic [2:0]      w_ce;
  logic [3:0]      w_cf;
  logic [11:0]     w_mag;
  logic [3:0]      w_lz, w_e_raw;
  logic [4:0]      w_top5, w_fr;

  // Cyclic search for the first asserted req at or after r_rr_ptr.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      logic [TAGW:0] cand;
      cand = {1'b0, r_rr_ptr} + (TAGW+1)'(i);
      if (cand >= (TAGW+1)'(NREQ)) cand = cand - (TAGW+1)'(NREQ);
      for (int j = 0; j < NREQ; j++) begin
        if (!w_grant_any && s_bus.req[j] && cand == (TAGW+1)'(j)) begin
          w_grant_any = 1'b1;
          w_grant_idx = TAGW'(j);
        end
      end
    end
  end

  always_comb begin
    w_din_sel = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_grant_idx == TAGW'(j)) w_din_sel = s_bus.din[12*j +: 12];
    end
  end

  assign w_ptr_next = (r_tag_q == TAGW'(NREQ-1)) ? '0 : r_tag_q + TAGW'(1);

  // Converter: w_top5 holds the leading one, three bits below it, then the round bit.
  always_comb begin
    w_cs = r_d_q[11];
    if (r_d_q == 12'h800)  w_mag = 12'h7FF;
    else if (r_d_q[11])    w_mag = -r_d_q;
    else                   w_mag = r_d_q;
    w_lz = 4'd12;
    for (int i = 0; i < 12; i++) begin
      if (w_mag[i]) w_lz = 4'(11 - i);
    end
    w_top5  = 5'(w_mag >> (4'd7 - w_lz));
    w_fr    = {1'b0, w_top5[4:1]} + {4'b0, w_top5[0]};
    w_e_raw = 4'd8 - w_lz;
    w_ce    = 3'd0;
    w_cf    = 4'd0;
    if (w_lz >= 4'd8) begin
      w_ce = 3'd0;
      w_cf = w_mag[3:0];
    end else if (w_fr[4]) begin
      if (w_e_raw == 4'd7) begin
        w_ce = 3'd7;
        w_cf = 4'b1111;
      end else begin
        w_ce = w_e_raw[2:0] + 3'd1;
        w_cf = 4'b1000;
      end
    end else begin
      w_ce = w_e_raw[2:0];
      w_cf = w_fr[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_grant_any) w_next = S_CONV;
      S_CONV: w_next = S_DONE;
`ifdef FP_CONV_BACKPRESSURE_EN
      S_DONE: w_next = s_bus.out_ready ? S_IDLE : S_WAIT;
      S_WAIT: if (s_bus.out_ready) w_next = S_IDLE;
`else
      S_DONE: w_next = S_IDLE;
      S_WAIT: w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
`ifdef FP_CONV_BACKPRESSURE_EN
    w_valid = (r_state == S_DONE) || (r_state == S_WAIT);
    w_fire  = w_valid && s_bus.out_ready;
`else
    w_valid = (r_state == S_DONE);
    w_fire  = w_valid;
`endif
    s_bus.out_valid = w_valid;
    s_bus.busy      = (r_state != S_IDLE);
    s_bus.dbg_state = r_state;
    s_bus.ack       = '0;
    for (int j = 0; j < NREQ; j++) begin
      s_bus.ack[j] = w_fire && (r_tag_q == TAGW'(j));
    end
  end

  assign s_bus.out_tag = r_out_tag;
  assign s_bus.out_s   = r_out_s;
  assign s_bus.out_e   = r_out_e;
  assign s_bus.out_f   = r_out_f;

  // Results are captured only in CONV so they stay stable while a result is pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_tag_q   <= '0;
      r_d_q     <= '0;
      r_out_tag <= '0;
      r_out_s   <= 1'b0;
      r_out_e   <= 3'd0;
      r_out_f   <= 4'd0;
    end else begin
      if (r_state == S_IDLE && w_grant_any) begin
        r_d_q   <= w_din_sel;
        r_tag_q <= w_grant_idx;
      end
      if (r_state == S_CONV) begin
        r_out_tag <= r_tag_q;
        r_out_s   <= w_cs;
        r_out_e   <= w_ce;
        r_out_f   <= w_cf;
      end
      if (w_fire) r_rr_ptr <= w_ptr_next;
    end
  end
endmodule

// File: tb/tb_fp_conv_sched.sv
// Directed self-checking bench for fp_conv_sched; expected S/E/F values are hand-computed.
module tb_fp_conv_sched;
  localparam int NREQ = 4;
  localparam int TAGW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fp_conv_sched_if #(.NREQ(NREQ), .TAGW(TAGW)) bus();

  fp_conv_sched #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_bus (bus)
  );

  task automatic set_req(input int idx, input logic [11:0] d);
    bus.din[12*idx +: 12] = d;
    bus.req[idx] = 1'b1;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    while (cycles < budget && !ok) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.out_valid) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'hF;
    bus.din = 48'h123_456_789_ABC;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({bus.ack, bus.out_valid, bus.out_tag, bus.out_s, bus.out_e, bus.out_f, bus.busy, bus.dbg_state} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: ack=%b valid=%b tag=%0d s=%b e=%0d f=%b busy=%b state=%0d, all required 0",
                 bus.ack, bus.out_valid, bus.out_tag, bus.out_s, bus.out_e, bus.out_f, bus.busy, bus.dbg_state);
      end
    end
    bus.req = '0;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    set_req(0, 12'h001);
    @(posedge clk); #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_conv: valid=%b busy=%b, required valid=0 busy=1", bus.out_valid, bus.busy);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({bus.out_valid, bus.ack} !== 5'b1_0001) begin
      n_fail++;
      $display("FAIL latency_done: valid=%b ack=%b, required valid=1 ack=0001", bus.out_valid, bus.ack);
    end
    n_tests++;
    if ({bus.out_tag, bus.out_s, bus.out_e, bus.out_f} !== {2'd0, 1'b0, 3'd0, 4'b0001}) begin
      n_fail++;
      $display("FAIL latency_result: tag=%0d s=%b e=%0d f=%b, required tag=0 s=0 e=0 f=0001",
               bus.out_tag, bus.out_s, bus.out_e, bus.out_f);
    end
    bus.req[0] = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({bus.out_valid, bus.ack, bus.busy, bus.out_f} !== {1'b0, 4'b0000, 1'b0, 4'b0001}) begin
      n_fail++;
      $display("FAIL hold_after_ack: valid=%b ack=%b busy=%b f=%b, required valid=0 ack=0000 busy=0 f=0001 held",
               bus.out_valid, bus.ack, bus.busy, bus.out_f);
    end
  endtask

  task automatic test_convert();
    logic [11:0] tv_din [12];
    logic [7:0]  tv_exp [12];
    bit ok;
    int cyc;
    int idx;
    tv_din = '{12'hC2F, 12'h800, 12'h000, 12'h07F, 12'h010, 12'h00F,
               12'h7FF, 12'h3FF, 12'hFFF, 12'h400, 12'h0AB, 12'hF00};
    tv_exp = '{{1'b1, 3'd6, 4'b1111}, {1'b1, 3'd7, 4'b1111}, {1'b0, 3'd0, 4'b0000},
               {1'b0, 3'd4, 4'b1000}, {1'b0, 3'd1, 4'b1000}, {1'b0, 3'd0, 4'b1111},
               {1'b0, 3'd7, 4'b1111}, {1'b0, 3'd7, 4'b1000}, {1'b1, 3'd0, 4'b0001},
               {1'b0, 3'd7, 4'b1000}, {1'b0, 3'd4, 4'b1011}, {1'b1, 3'd5, 4'b1000}};
    for (int k = 0; k < 12; k++) begin
      idx = (k + 1) % NREQ;
      set_req(idx, tv_din[k]);
      wait_done(8, ok, cyc);
      n_tests++;
      if (!ok || bus.ack !== (NREQ'(1) << idx) || bus.out_tag !== TAGW'(idx)) begin
        n_fail++;
        $display("FAIL convert_ack[%0d]: valid_seen=%0d ack=%b tag=%0d, required ack=%b tag=%0d",
                 k, ok, bus.ack, bus.out_tag, NREQ'(1) << idx, idx);
      end
      n_tests++;
      if ({bus.out_s, bus.out_e, bus.out_f} !== tv_exp[k]) begin
        n_fail++;
        $display("FAIL convert_sef[%0d] din=%h: s=%b e=%0d f=%b, required s=%b e=%0d f=%b",
                 k, tv_din[k], bus.out_s, bus.out_e, bus.out_f, tv_exp[k][7], tv_exp[k][6:4], tv_exp[k][3:0]);
      end
      bus.req[idx] = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    logic [11:0] rr_din [4];
    logic [7:0]  rr_exp [4];
    bit ok;
    int cyc;
    int exp_cyc;
    rr_din = '{12'h001, 12'hC2F, 12'h800, 12'h07F};
    rr_exp = '{{1'b0, 3'd0, 4'b0001}, {1'b1, 3'd6, 4'b1111},
               {1'b1, 3'd7, 4'b1111}, {1'b0, 3'd4, 4'b1000}};
    do_reset();
    for (int j = 0; j < NREQ; j++) set_req(j, rr_din[j]);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NREQ; k++) begin
        exp_cyc = (r == 0 && k == 0) ? 2 : 3;
        wait_done(10, ok, cyc);
        n_tests++;
        if (!ok || cyc != exp_cyc || bus.ack !== (NREQ'(1) << k) || bus.out_tag !== TAGW'(k)) begin
          n_fail++;
          $display("FAIL rr_order r%0d k%0d: valid_seen=%0d cycles=%0d ack=%b tag=%0d, required cycles=%0d ack=%b tag=%0d",
                   r, k, ok, cyc, bus.ack, bus.out_tag, exp_cyc, NREQ'(1) << k, k);
        end
        n_tests++;
        if ({bus.out_s, bus.out_e, bus.out_f} !== rr_exp[k]) begin
          n_fail++;
          $display("FAIL rr_sef r%0d k%0d: s=%b e=%0d f=%b, required %b", r, k,
                   bus.out_s, bus.out_e, bus.out_f, rr_exp[k]);
        end
        bus.req[k] = 1'b0;
      end
      if (r == 0) for (int j = 0; j < NREQ; j++) set_req(j, rr_din[j]);
    end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    int cyc;
    do_reset();
    set_req(2, 12'h000);
    wait_done(8, ok, cyc);
    n_tests++;
    if (!ok || bus.out_tag !== 2'd2) begin
      n_fail++;
      $display("FAIL midrst_setup: valid_seen=%0d tag=%0d, required tag=2", ok, bus.out_tag);
    end
    bus.req[2] = 1'b0;
    set_req(3, 12'h400);
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus.dbg_state !== 2'd1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_in_conv: state=%0d busy=%b, required state=1 busy=1", bus.dbg_state, bus.busy);
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({bus.out_valid, bus.ack, bus.busy} !== 6'b0) begin
        n_fail++;
        $display("FAIL midrst_abandon c%0d: valid=%b ack=%b busy=%b, required all 0",
                 c, bus.out_valid, bus.ack, bus.busy);
      end
    end
    rst = 1'b0;
    set_req(1, 12'h010);
    wait_done(8, ok, cyc);
    n_tests++;
    if (!ok || bus.out_tag !== 2'd1 || bus.ack !== 4'b0010 || {bus.out_e, bus.out_f} !== {3'd1, 4'b1000}) begin
      n_fail++;
      $display("FAIL midrst_ptr_zero: valid_seen=%0d tag=%0d ack=%b e=%0d f=%b, required tag=1 ack=0010 e=1 f=1000",
               ok, bus.out_tag, bus.ack, bus.out_e, bus.out_f);
    end
    bus.req[1] = 1'b0;
    wait_done(8, ok, cyc);
    n_tests++;
    if (!ok || bus.out_tag !== 2'd3 || bus.ack !== 4'b1000 ||
        {bus.out_s, bus.out_e, bus.out_f} !== {1'b0, 3'd7, 4'b1000}) begin
      n_fail++;
      $display("FAIL midrst_reserve: valid_seen=%0d tag=%0d ack=%b s=%b e=%0d f=%b, required tag=3 ack=1000 s=0 e=7 f=1000",
               ok, bus.out_tag, bus.ack, bus.out_s, bus.out_e, bus.out_f);
    end
    bus.req[3] = 1'b0;
  endtask

`ifdef FP_CONV_BACKPRESSURE_EN
  task automatic test_backpressure();
    bit ok;
    int cyc;
    do_reset();
    bus.out_ready = 1'b0;
    set_req(0, 12'h07F);
    wait_done(8, ok, cyc);
    n_tests++;
    if (!ok || bus.ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_first: valid_seen=%0d ack=%b, required ack=0000", ok, bus.ack);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({bus.out_valid, bus.ack, bus.out_tag, bus.out_s, bus.out_e, bus.out_f} !==
          {1'b1, 4'b0000, 2'd0, 1'b0, 3'd4, 4'b1000}) begin
        n_fail++;
        $display("FAIL bp_hold c%0d: valid=%b ack=%b tag=%0d s=%b e=%0d f=%b, required valid=1 ack=0000 tag=0 s=0 e=4 f=1000",
                 c, bus.out_valid, bus.ack, bus.out_tag, bus.out_s, bus.out_e, bus.out_f);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    n_tests++;
    if ({bus.out_valid, bus.ack} !== 5'b1_0001) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b ack=%b, required valid=1 ack=0001", bus.out_valid, bus.ack);
    end
    bus.req[0] = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({bus.out_valid, bus.ack, bus.dbg_state} !== 7'b0) begin
      n_fail++;
      $display("FAIL bp_idle: valid=%b ack=%b state=%0d, required valid=0 ack=0000 state=0",
               bus.out_valid, bus.ack, bus.dbg_state);
    end
  endtask
`endif

  initial begin
    bus.req = '0;
    bus.din = '0;
`ifdef FP_CONV_BACKPRESSURE_EN
    bus.out_ready = 1'b1;
`endif
    test_reset();
    test_latency();
    test_convert();
    test_round_robin();
    test_reset_midflight();
`ifdef FP_CONV_BACKPRESSURE_EN
    test_backpressure();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_conv_sched.md
Name: fp_conv_sched

Overview:
Round-robin scheduler that shares one combinational floating_point_converter (12-bit two's-complement D -> S, E[2:0], F[3:0]) among NREQ requesters. Each granted sample is latched and run through the converter, and the registered result is returned with a requester tag and a one-cycle ack. The block sits between the switch/sample sources and the display/readout logic of the lab design.

Parameters:
NREQ, 4, number of requesters (2..8)
TAGW, 2, tag width; must satisfy 2^TAGW >= NREQ

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req  in  NREQ  per-requester request; held until matching ack
din  in  12*NREQ  flat sample bus; requester i occupies din[12*i+11:12*i]
ack  out  NREQ  one-hot pulse, one cycle; the requester's sample is consumed and its result is valid
out_valid  out  1  result valid
out_tag  out  TAGW  index of the requester that owns the result
out_s  out  1  sign
out_e  out  3  exponent
out_f  out  4  significand
busy  out  1  high in any state other than IDLE

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst). All state is updated on the rising edge of clk.
- Reset values: state=IDLE, rr_ptr=0, ack=0, out_valid=0, out_tag=0, out_s=0, out_e=0, out_f=0, busy=0.
- FSM:
  - IDLE: if any req, grant the first asserted req at or after rr_ptr (cyclic search). Latch that requester's din into d_q and its index into tag_q. Go to CONV. Otherwise stay in IDLE.
  - CONV: the converter is driven from d_q. Register its S/E/F into out_s/out_e/out_f and tag_q into out_tag. Go to DONE.
  - DONE: out_valid=1 and ack[tag_q]=1 for exactly this cycle. rr_ptr <= (tag_q+1) mod NREQ. Go to IDLE (or WAIT, see Optional Feature).
- Latency: req sampled at edge N -> out_valid/ack high during cycle N+2. Peak throughput is one conversion per 3 cycles.
- out_s/out_e/out_f/out_tag hold their last value when out_valid=0.
- Converter arithmetic (for checking):
  - S = D[11]. Magnitude = |D|; -2048 saturates to 2047.
  - lz = leading zeros of the 12-bit magnitude.
  - If lz >= 8: E=0, F=mag[3:0].
  - Else: E=8-lz, F = the 4 bits below and including the leading one, rounded by the next bit.
  - If rounding carries out of F: F=1000, E+1.
  - If E would exceed 7: saturate to E=7, F=1111.
- Commit rule: the transaction is committed at grant. Deasserting req after grant does not cancel it; ack still fires.
- Requester contract: drop req the cycle after ack. A req still high in the IDLE cycle after ack is treated as a new request, subject to round-robin order.
- A req that asserts while busy waits. No request is lost. Starvation bound: NREQ-1 other grants.
- NREQ=1: rr_ptr stays 0.
- rst asserted in any state: the in-flight transaction is abandoned with no ack and no out_valid. The next edge after rst releases is evaluated from IDLE with rr_ptr=0.

Optional Feature:
Macro FP_CONV_BACKPRESSURE_EN.
- Defined:
  - Adds input out_ready (1 bit).
  - Adds state WAIT, entered from DONE when out_ready=0 in DONE.
  - out_valid stays high and out_* stay stable through DONE/WAIT until a cycle with out_ready=1.
  - ack pulses only in the cycle where out_valid && out_ready. rr_ptr updates then, and the FSM returns to IDLE next.
  - rst clears WAIT.
- Not defined:
  - No out_ready port and no WAIT state.
  - out_valid/ack are single-cycle pulses in DONE, as described above.

Test Plan:
- After rst, req[0]=1 with din0=12'h001 -> at cycle N+2 ack=0001, out_valid=1, tag=0, S=0, E=0, F=0001. All outputs were 0 during reset.
- req[1]=1 with din1=12'b110000101111 (-977) -> tag=1, S=1, E=6, F=1111.
- req[2]=1 with din2=12'h800 (-2048) -> S=1, E=7, F=1111 (saturation). Also check din=12'h000 -> S=0, E=0, F=0.
- All four req high and held, each dropped after its ack -> ack order 0,1,2,3. Next round starting from rr_ptr=0 again grants 0 first. out_valid is spaced every 3 cycles.
- Assert rst during CONV for req[3] -> no ack, no out_valid. rr_ptr=0 afterwards. req[3] still high is then re-served normally.
- (FP_CONV_BACKPRESSURE_EN) out_ready=0 for 5 cycles while a result is pending -> out_valid held and out_* stable, no ack. out_ready=1 -> a single ack pulse in that cycle, and IDLE on the next cycle.
